// File: rtl/maxpool1_bin_pkg.sv
// Shared conv1/pool1 geometry constants and a counter-width helper.
// Pure declarations; no timing or flow-control behaviour.
package maxpool1_bin_pkg;

    localparam int IMG_W    = 28;
    localparam int CONV1_K  = 3;
    localparam int CONV1_W  = IMG_W - CONV1_K + 1;
    localparam int CONV1_CH = 8;
    localparam int POOL1_W  = CONV1_W / 2;
    localparam int CNT_W    = $clog2(CONV1_W);

    // Width of a counter/address covering 0..depth-1, never below one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/maxpool1_linebuf.sv
// One-row store of horizontal pair ORs: one write port, one async read port, no reset.
// Write lands on the next clk; read is combinational; no backpressure.
module maxpool1_linebuf
    import maxpool1_bin_pkg::*;
#(
    parameter int DEPTH = POOL1_W,
    parameter int CH    = CONV1_CH,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [CH-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [CH-1:0] rdata
);

    logic [CH-1:0] mem_q [DEPTH];
    logic [CH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Contents are intentionally unreset: even rows rewrite every entry before use.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/maxpool1_bin.sv
// 2x2/stride-2 binary max-pool (per-channel OR) over a raster conv1 stream.
// Output registered 1 clk after the beat closing a window; valid_in gaps freeze state, no backpressure.
module maxpool1_bin
    import maxpool1_bin_pkg::*;
#(
    parameter int IN_W = CONV1_W,
    parameter int IN_H = CONV1_W,
    parameter int CH   = CONV1_CH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] conv1_in,
    input  logic          valid_in,
    output logic [CH-1:0] pool_out,
    output logic          valid_out,
    output logic          frame_done
);

    localparam int COL_W = addr_w(IN_W);
    localparam int ROW_W = addr_w(IN_H);
    localparam int LB_D  = (IN_W / 2 > 0) ? IN_W / 2 : 1;
    localparam int LB_AW = addr_w(LB_D);

    localparam logic [COL_W-1:0] COL_MAX  = COL_W'(IN_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(IN_H - 1);
    // Last odd column/row that actually closes a window (floor for odd sizes).
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(2 * (IN_W / 2) - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(2 * (IN_H / 2) - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CH-1:0]    hold_q, hold_d;
    logic [CH-1:0]    pool_q, pool_d;
    logic             vld_q, vld_d;
    logic             done_q, done_d;

    logic             lb_we;
    logic [LB_AW-1:0] lb_addr;
    logic [CH-1:0]    lb_rdata;
    logic [CH-1:0]    pair;

    assign lb_addr = LB_AW'(col_q >> 1);
    assign pair    = hold_q | conv1_in;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        hold_d = hold_q;
        pool_d = pool_q;
        vld_d  = 1'b0;
        done_d = 1'b0;
        lb_we  = 1'b0;
        if (valid_in) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (!col_q[0]) begin
                hold_d = conv1_in;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                pool_d = lb_rdata | pair;
                vld_d  = 1'b1;
                done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            hold_q <= '0;
            pool_q <= '0;
            vld_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            hold_q <= hold_d;
            pool_q <= pool_d;
            vld_q  <= vld_d;
            done_q <= done_d;
        end
    end

    maxpool1_linebuf #(
        .DEPTH (LB_D),
        .CH    (CH),
        .AW    (LB_AW)
    ) u_linebuf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (pair),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    assign pool_out   = pool_q;
    assign valid_out  = vld_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_maxpool1_bin.sv
// Scoreboard bench for maxpool1_bin: a frame-image model computes each 2x2 OR window.
// Inputs driven on negedge; outputs sampled 1 time unit after posedge.
module tb_maxpool1_bin;

    localparam int W = 26;
    localparam int H = 26;

    logic       clk;
    logic       rst_n;
    logic [7:0] conv1_in;
    logic       valid_in;
    logic [7:0] pool_out;
    logic       valid_out;
    logic       frame_done;

    int n_chk = 0;
    int n_err = 0;
    int n_out = 0;
    int n_done = 0;
    int n_nz = 0;

    logic [8:0] exp_q [$];
    logic [7:0] img [H][W];
    int mr = 0;
    int mc = 0;

    maxpool1_bin dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .conv1_in   (conv1_in),
        .valid_in   (valid_in),
        .pool_out   (pool_out),
        .valid_out  (valid_out),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) begin
        logic [8:0] e;
        #1;
        if (valid_out) begin
            n_out++;
            if (frame_done) n_done++;
            if (pool_out != 8'h00) n_nz++;
            if (exp_q.size() == 0) begin
                chk("stray_valid_out", exp_q.size() > 0, 1);
            end else begin
                e = exp_q.pop_front();
                chk("pool_out", pool_out, e[7:0]);
                chk("frame_done", frame_done, e[8]);
            end
        end else if (frame_done) begin
            chk("frame_done_without_valid", valid_out, 1);
        end
    end

    function automatic logic [7:0] pix(input int mode, input int r, input int c);
        logic [7:0] v;
        v = 8'h00;
        case (mode)
            0: v = 8'hFF;
            2: v = (r == 5 && c == 7) ? 8'h04 : 8'h00;
            3: v = 8'($urandom_range(255));
            4: for (int k = 1; k <= 8; k++) v[k-1] = ((r + c + k) % 2) == 1;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    task automatic beat(input logic [7:0] d, input int gap);
        logic [7:0] w;
        while (int'($urandom_range(99)) < gap) begin
            valid_in = 1'b0;
            conv1_in = 8'($urandom_range(255));
            @(negedge clk);
        end
        valid_in = 1'b1;
        conv1_in = d;
        img[mr][mc] = d;
        if ((mr % 2) == 1 && (mc % 2) == 1) begin
            w = img[mr-1][mc-1] | img[mr-1][mc] | img[mr][mc-1] | d;
            exp_q.push_back({(mr == H - 1 && mc == W - 1), w});
        end
        mc++;
        if (mc == W) begin
            mc = 0;
            mr++;
            if (mr == H) mr = 0;
        end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic send(input int mode, input int gap, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            beat(pix(mode, mr, mc), gap);
        end
    endtask

    task automatic end_test(input string tag, input int exp_out, input int exp_done);
        repeat (4) @(negedge clk);
        chk({tag, "_queue_drained"}, exp_q.size(), 0);
        chk({tag, "_out_count"}, n_out, exp_out);
        chk({tag, "_done_count"}, n_done, exp_done);
        n_out = 0;
        n_done = 0;
        n_nz = 0;
    endtask

    initial begin
        rst_n    = 1'b0;
        valid_in = 1'b0;
        conv1_in = 8'h00;
        #12;
        chk("rst_pool_out", pool_out, 0);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_frame_done", frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        send(0, 0, W * H);
        end_test("ones", 169, 1);

        send(2, 0, W * H);
        chk("single_nonzero_count", n_nz, 1);
        end_test("single", 169, 1);

        send(3, 50, W * H);
        end_test("random_gaps", 169, 1);

        send(3, 0, 300);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_pool_out", pool_out, 0);
        chk("midrst_valid_out", valid_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_queue_drained", exp_q.size(), 0);
        exp_q.delete();
        mr = 0;
        mc = 0;
        n_out = 0;
        n_done = 0;
        n_nz = 0;
        send(3, 10, W * H);
        end_test("after_reset", 169, 1);

        send(0, 0, W * H);
        send(1, 0, W * H);
        end_test("back_to_back", 338, 2);

        send(4, 0, W * H);
        end_test("checker", 169, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
